// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction decoder: opcodes, R-type functs,
// ALU operations and the layout of the registered control word.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b001010;
    localparam logic [5:0] OP_LOAD  = 6'b001011;
    localparam logic [5:0] OP_STORE = 6'b001100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOP = 6'b011111;

    typedef enum logic [3:0] {
        AluAdd  = 4'h0,
        AluSub  = 4'h1,
        AluAnd  = 4'h2,
        AluOr   = 4'h3,
        AluNone = 4'hF
    } alu_op_e;

    // Declared MSB first so the packed layout matches the bit offsets of controlSignal.
    typedef struct packed {
        logic [10:0] reserved_hi;
        logic [4:0]  dest_reg;
        logic [4:0]  reserved_lo;
        logic        illegal;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        alu_op_e     alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational decode of one instruction into a control word.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    input  logic [5:0] i_funct,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl        = '0;
        o_ctrl.alu_op = AluNone;
        unique case (i_opcode)
            OP_RTYPE: begin
                unique case (i_funct)
                    F_ADD, F_SUB, F_AND, F_OR: begin
                        unique case (i_funct)
                            F_ADD:   o_ctrl.alu_op = AluAdd;
                            F_SUB:   o_ctrl.alu_op = AluSub;
                            F_AND:   o_ctrl.alu_op = AluAnd;
                            default: o_ctrl.alu_op = AluOr;
                        endcase
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.reg_dst   = 1'b1;
                        o_ctrl.dest_reg  = i_rd;
                    end
                    F_NOP:   o_ctrl.alu_op = AluNone;
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                o_ctrl.alu_op     = AluAdd;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.dest_reg   = i_rt;
            end
            OP_STORE: begin
                o_ctrl.alu_op    = AluAdd;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: combinational decode followed by a single
// synchronously reset output register (1-cycle latency).
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [31:0] controlSignal
);

    ctrl_word_t w_ctrl;
    ctrl_word_t r_ctrl;

    // rs and shamt fields do not influence the control word.
    logic w_unused_fields;
    assign w_unused_fields = ^{instruction[25:21], instruction[10:6]};

    ctrl_decode u_decode (
        .i_opcode (instruction[31:26]),
        .i_rt     (instruction[20:16]),
        .i_rd     (instruction[15:11]),
        .i_funct  (instruction[5:0]),
        .o_ctrl   (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign controlSignal = r_ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected words are queued when an
// instruction is driven and compared one edge later.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] controlSignal;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] exp_q[$];

    control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction   (instruction),
        .controlSignal (controlSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference decode built from the field map as literal bit weights.
    function automatic logic [31:0] ref_ctrl(input logic [31:0] ins);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rt_f;
        logic [31:0] rd_f;
        op   = ins[31:26];
        fn   = ins[5:0];
        rt_f = {27'd0, ins[20:16]} << 16;
        rd_f = {27'd0, ins[15:11]} << 16;
        if (op == 6'b001010) begin
            case (fn)
                6'b100000: return 32'h0000_0030 | rd_f;
                6'b100010: return 32'h0000_0031 | rd_f;
                6'b100100: return 32'h0000_0032 | rd_f;
                6'b100101: return 32'h0000_0033 | rd_f;
                6'b011111: return 32'h0000_000F;
                default:   return 32'h0000_040F;
            endcase
        end else if (op == 6'b001011) begin
            return 32'h0000_02D0 | rt_f;
        end else if (op == 6'b001100) begin
            return 32'h0000_0140;
        end
        return 32'h0000_040F;
    endfunction

    // Drive on the falling edge, push the expectation, compare just after the rising edge.
    task automatic apply(input string tag, input logic rst, input logic [31:0] ins,
                         input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        rst_n       = rst;
        instruction = ins;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, controlSignal, e);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] held;
        logic [5:0]  ops[4];
        logic [5:0]  fns[7];
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        instruction = 32'h2C23_0000;

        apply("reset", 1'b0, 32'h2C23_0000, 32'h0000_0000);

        apply("r_add", 1'b1, 32'b001010_00001_00011_01000_01010_100000, 32'h0008_0030);
        apply("r_sub", 1'b1, 32'b001010_00001_00011_01000_01010_100010, 32'h0008_0031);
        apply("r_and", 1'b1, 32'b001010_00001_00011_01000_01010_100100, 32'h0008_0032);
        apply("r_or",  1'b1, 32'b001010_00001_00011_01000_01010_100101, 32'h0008_0033);
        apply("r_nop", 1'b1, 32'b001010_00000_00000_00000_01010_011111, 32'h0000_000F);
        apply("load",  1'b1, 32'b001011_00001_00011_0000000000000000, 32'h0003_02D0);
        apply("store", 1'b1, 32'b001100_00001_00011_0000000000000000, 32'h0000_0140);
        apply("ill_op",    1'b1, 32'h0000_0000, 32'h0000_040F);
        apply("ill_funct", 1'b1, 32'b001010_00001_00011_01000_00000_000000, 32'h0000_040F);
        apply("add_r0",    1'b1, 32'b001010_00001_00011_00000_00000_100000, 32'h0000_0030);
        apply("load_r31",  1'b1, 32'b001011_11111_11111_1111111111111111, 32'h001F_02D0);

        // Reset must override a decodable instruction.
        apply("reset_wins", 1'b0, 32'b001011_00001_00011_0000000000000000, 32'h0000_0000);

        // Output holds until the next edge after a mid-cycle instruction change.
        apply("lag_setup", 1'b1, 32'b001011_00001_00101_0000000000000000, 32'h0005_02D0);
        held = 32'h0005_02D0;
        @(negedge clk);
        instruction = 32'b001100_00001_00011_0000000000000000;
        #1;
        check_eq("lag_hold", controlSignal, held);
        exp_q.push_back(32'h0000_0140);
        @(posedge clk);
        #1;
        check_eq("lag_update", controlSignal, exp_q.pop_front());

        ops = '{6'b001010, 6'b001011, 6'b001100, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011111, 6'b000001, 6'b100001};
        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            ins[31:26] = ($urandom_range(0, 4) == 0) ? ins[31:26] : ops[$urandom_range(0, 3)];
            ins[5:0]   = ($urandom_range(0, 4) == 0) ? ins[5:0]   : fns[$urandom_range(0, 6)];
            apply("random", 1'b1, ins, ref_ctrl(ins));
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
